serial_sub: RTL and testbench

- Bit-serial, LSB-first WIDTH-bit subtractor with borrow-in and borrow-out: computes a - b - bin.
- Inverse operation to the team's ripple adder blocks (add2/add3 family), with the arithmetic folded over time instead of space.
- Uses one full-subtractor cell plus a borrow flop, with valid/ready handshakes on input and output.
- Intended as a punching/hierarchy test target with real state: FSM, counter, shift registers.

---
 rtl/serial_sub.sv | 156 +++++++++++++++
 tb/tb_serial_sub.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial LSB-first subtractor computing a - b - bin with valid/ready handshakes.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
`timescale 1ns/1ps
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             bout,
  output logic             ovf
`else
  output logic             bout
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             d_bit, br_next;
  logic [WIDTH-1:0] shifted;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    res_d       = res_q;
    diff_d      = diff_q;
    br_d        = br_q;
    bout_d      = bout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    ovf_d       = ovf_q;
`endif
    // One full-subtractor cell on the current LSBs.
    d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
    br_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    shifted = {d_bit, res_q};

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sa_d       = a;
          sb_d       = b;
          br_d       = bin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d    = a[WIDTH-1];
          b_msb_d    = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        br_d  = br_next;
        res_d = shifted[WIDTH-1:1];
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // The final bit is folded straight into the visible result.
          diff_d      = shifted;
          bout_d      = br_next;
          out_valid_d = 1'b1;
          state_d     = DONE;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d       = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sa_q        <= '0;
      sb_q        <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      br_q        <= 1'b0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      res_q       <= res_d;
      diff_q      <= diff_d;
      br_q        <= br_d;
      bout_q      <= bout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - self-checking bench for serial_sub against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_sub;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, bout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff),
`ifdef SERIAL_SUB_OVF_EN
    .bout(bout), .ovf(ovf)
`else
    .bout(bout)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: widen by one bit, the top bit of the difference is the borrow.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
  endfunction

  task automatic expect_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] r;
    r = ref_sub(x, y, c);
    chk({tag, ":diff"}, diff, r[W-1:0]);
    chk({tag, ":bout"}, bout, r[W]);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, ":ovf"}, ovf, (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]));
`endif
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      tick;
      n++;
    end
    chk({tag, ":lat"}, n, W);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick;
      n++;
    end
    chk({tag, ":in_ready"}, in_ready, 1'b1);
    a = x; b = y; bin = c; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    wait_out(tag);
    expect_result(tag, x, y, c);
    tick;
    chk({tag, ":ov_drop"}, out_valid, 1'b0);
    chk({tag, ":rdy_back"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [W-1:0] xs[4];
    logic [W-1:0] ys[4];
    logic         cs[4];
    int           acc_cyc[4];
    int           k, got, cyc;
    logic         acc;

    repeat (3) tick;
    chk("rst:in_ready", in_ready, 1'b1);
    chk("rst:out_valid", out_valid, 1'b0);
    chk("rst:diff", diff, '0);
    chk("rst:bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst:ovf", ovf, 1'b0);
`endif
    rst_n = 1'b1;
    tick;

    do_op("t1", 8'h05, 8'h03, 1'b0);
    do_op("t2a", 8'h00, 8'h01, 1'b0);
    do_op("t2b", 8'h10, 8'h0F, 1'b1);
    do_op("t2c", 8'hFF, 8'hFF, 1'b1);

    out_ready = 1'b0;
    a = 8'hA5; b = 8'h5A; bin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    wait_out("t3");
    for (int i = 0; i < 6; i++) begin
      chk("t3:hold_diff", diff, 8'h4B);
      chk("t3:hold_bout", bout, 1'b0);
      chk("t3:hold_valid", out_valid, 1'b1);
      chk("t3:hold_rdy", in_ready, 1'b0);
      if (i == 2) begin
        a = 8'h12; b = 8'h34; bin = 1'b1; in_valid = 1'b1;
      end
      tick;
    end
    out_ready = 1'b1;
    tick;
    chk("t3:hs_valid", out_valid, 1'b0);
    chk("t3:hs_rdy", in_ready, 1'b1);
    tick;
    chk("t3:accepted", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_out("t3b");
    expect_result("t3b", 8'h12, 8'h34, 1'b1);
    tick;

    a = 8'h33; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    rst_n = 1'b0;
    #1;
    chk("t4:valid", out_valid, 1'b0);
    chk("t4:rdy", in_ready, 1'b1);
    chk("t4:diff", diff, '0);
    tick;
    chk("t4:still_idle", out_valid, 1'b0);
    rst_n = 1'b1;
    tick;
    do_op("t4b", 8'h33, 8'h11, 1'b0);

    for (int i = 0; i < 4; i++) begin
      xs[i] = W'($urandom); ys[i] = W'($urandom); cs[i] = 1'($urandom);
      acc_cyc[i] = 0;
    end
    k = 0; got = 0; cyc = 0;
    a = xs[0]; b = ys[0]; bin = cs[0]; in_valid = 1'b1;
    while (got < 4 && cyc < 400) begin
      acc = in_valid && in_ready;
      tick;
      cyc++;
      if (acc) begin
        acc_cyc[k] = cyc;
        k++;
        if (k < 4) begin
          a = xs[k]; b = ys[k]; bin = cs[k];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        expect_result("t5", xs[got], ys[got], cs[got]);
        got++;
      end
    end
    chk("t5:count", got, 4);
    for (int i = 1; i < 4; i++) chk("t5:spacing", acc_cyc[i] - acc_cyc[i-1], W + 2);
    tick;

    do_op("t6a", 8'h80, 8'h01, 1'b0);
    do_op("t6b", 8'h7F, 8'hFF, 1'b0);
    do_op("t6c", 8'h05, 8'h03, 1'b0);

    for (int i = 0; i < 16; i++) do_op("rnd", W'($urandom), W'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
